// File: rtl/cal_pkg.sv
// cal_pkg: calendar constants and month-length helpers shared by the date counter.
package cal_pkg;
   localparam logic [3:0] MON_JAN = 4'd0;
   localparam logic [3:0] MON_FEB = 4'd1;
   localparam logic [3:0] MON_MAR = 4'd2;
   localparam logic [3:0] MON_APR = 4'd3;
   localparam logic [3:0] MON_MAY = 4'd4;
   localparam logic [3:0] MON_JUN = 4'd5;
   localparam logic [3:0] MON_JUL = 4'd6;
   localparam logic [3:0] MON_AUG = 4'd7;
   localparam logic [3:0] MON_SEP = 4'd8;
   localparam logic [3:0] MON_OCT = 4'd9;
   localparam logic [3:0] MON_NOV = 4'd10;
   localparam logic [3:0] MON_DEC = 4'd11;
   localparam logic [2:0] DOW_SUN = 3'd0;
   localparam logic [2:0] DOW_MON = 3'd1;
   localparam logic [2:0] DOW_TUE = 3'd2;
   localparam logic [2:0] DOW_WED = 3'd3;
   localparam logic [2:0] DOW_THU = 3'd4;
   localparam logic [2:0] DOW_FRI = 3'd5;
   localparam logic [2:0] DOW_SAT = 3'd6;

   // Every fourth year is leap across 2000-2099, so only the low two bits matter.
   function automatic logic is_leap(input logic [1:0] yr_lo);
      return yr_lo == 2'd0;
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] mon, input logic leap);
      return (mon == MON_FEB) ? (leap ? 5'd29 : 5'd28) :
             (mon == MON_APR || mon == MON_JUN || mon == MON_SEP || mon == MON_NOV) ? 5'd30 : 5'd31;
   endfunction
endpackage

// File: rtl/cal_month_len.sv
// cal_month_len: combinational month length minus one for a given month and year.
module cal_month_len
   import cal_pkg::*;
#(
   parameter int YEAR_W  = 7,
   parameter int LEAP_EN = 1
) (
   input  logic [3:0]        mon,
   input  logic [YEAR_W-1:0] year,
   output logic [4:0]        len_m1
);
   always_comb len_m1 = days_in_month(mon, (LEAP_EN != 0) && is_leap(year[1:0])) - 5'd1;
endmodule

// File: rtl/cal_date_ct.sv
// cal_date_ct: day/month/year/day-of-week counter with leap years, validated load
// and year-wrap signalling; advances one day per en tick.
module cal_date_ct
   import cal_pkg::*;
#(
   parameter int YEAR_W   = 7,
   parameter int YEAR_MAX = 99,
   parameter int LEAP_EN  = 1,
   parameter int DOW_RST  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ld,
   input  logic [4:0]        ld_day,
   input  logic [3:0]        ld_mon,
   input  logic [YEAR_W-1:0] ld_year,
   input  logic [2:0]        ld_dow,
   output logic [4:0]        day,
   output logic [3:0]        mon,
   output logic [YEAR_W-1:0] year,
   output logic [2:0]        dow,
   output logic              last_day,
   output logic              last_mon,
   output logic              yr_wrap,
   output logic              ld_err
);
   localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);
   localparam logic [2:0]        DRST = 3'(DOW_RST);

   logic [4:0]        day_q, day_d, cur_len_m1, ld_len_m1;
   logic [3:0]        mon_q, mon_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [2:0]        dow_q, dow_d;
   logic              yr_wrap_q, yr_wrap_d, ld_err_q, ld_err_d;
   logic              ld_bad, year_end;

   cal_month_len #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_cur_len (
      .mon(mon_q), .year(year_q), .len_m1(cur_len_m1)
   );

   // Second instance sizes the incoming load date so an oversized day can be clamped.
   cal_month_len #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_ld_len (
      .mon(ld_mon), .year(ld_year), .len_m1(ld_len_m1)
   );

   always_comb begin
      last_day = day_q == cur_len_m1;
      last_mon = last_day && mon_q == MON_DEC;
      year_end = last_mon && year_q == YMAX;
      ld_bad   = ld_mon > MON_DEC || ld_year > YMAX || ld_dow > DOW_SAT;
   end

   always_comb begin
      day_d     = day_q;
      mon_d     = mon_q;
      year_d    = year_q;
      dow_d     = dow_q;
      yr_wrap_d = 1'b0;
      ld_err_d  = 1'b0;
      if (ld) begin
         ld_err_d = ld_bad;
         if (!ld_bad) begin
            day_d  = (ld_day > ld_len_m1) ? ld_len_m1 : ld_day;
            mon_d  = ld_mon;
            year_d = ld_year;
            dow_d  = ld_dow;
         end
      end else if (en) begin
         dow_d     = (dow_q == DOW_SAT) ? DOW_SUN : dow_q + 3'd1;
         day_d     = last_day ? 5'd0 : day_q + 5'd1;
         mon_d     = last_mon ? MON_JAN : last_day ? mon_q + 4'd1 : mon_q;
         year_d    = year_end ? '0 : last_mon ? year_q + 1'b1 : year_q;
         yr_wrap_d = year_end;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         day_q     <= '0;
         mon_q     <= MON_JAN;
         year_q    <= '0;
         dow_q     <= DRST;
         yr_wrap_q <= 1'b0;
         ld_err_q  <= 1'b0;
      end else begin
         day_q     <= day_d;
         mon_q     <= mon_d;
         year_q    <= year_d;
         dow_q     <= dow_d;
         yr_wrap_q <= yr_wrap_d;
         ld_err_q  <= ld_err_d;
      end
   end

   assign day     = day_q;
   assign mon     = mon_q;
   assign year    = year_q;
   assign dow     = dow_q;
   assign yr_wrap = yr_wrap_q;
   assign ld_err  = ld_err_q;
endmodule

// File: tb/tb_cal_date_ct.sv
// tb_cal_date_ct: directed checks of the date counter, with a second instance
// built without leap years sharing the same stimulus.
module tb_cal_date_ct;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, ld = 1'b0;
   logic [4:0] ld_day = '0;
   logic [3:0] ld_mon = '0;
   logic [6:0] ld_year = '0;
   logic [2:0] ld_dow = '0;
   logic [4:0] day, nl_day;
   logic [3:0] mon, nl_mon;
   logic [6:0] year, nl_year;
   logic [2:0] dow, nl_dow;
   logic       last_day, last_mon, yr_wrap, ld_err;
   logic       nl_last_day, nl_last_mon, nl_yr_wrap, nl_ld_err;
   int         checks = 0, errors = 0;

   cal_date_ct #(.YEAR_W(7), .YEAR_MAX(99), .LEAP_EN(1), .DOW_RST(6)) u_dut (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_day(ld_day), .ld_mon(ld_mon),
      .ld_year(ld_year), .ld_dow(ld_dow), .day(day), .mon(mon), .year(year), .dow(dow),
      .last_day(last_day), .last_mon(last_mon), .yr_wrap(yr_wrap), .ld_err(ld_err)
   );

   cal_date_ct #(.YEAR_W(7), .YEAR_MAX(99), .LEAP_EN(0), .DOW_RST(6)) u_nl (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_day(ld_day), .ld_mon(ld_mon),
      .ld_year(ld_year), .ld_dow(ld_dow), .day(nl_day), .mon(nl_mon), .year(nl_year), .dow(nl_dow),
      .last_day(nl_last_day), .last_mon(nl_last_mon), .yr_wrap(nl_yr_wrap), .ld_err(nl_ld_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] d, input logic [3:0] m, input logic [6:0] y, input logic [2:0] w);
      ld = 1'b1; ld_day = d; ld_mon = m; ld_year = y; ld_dow = w;
      step();
      ld = 1'b0;
   endtask

   task automatic tick();
      en = 1'b1;
      step();
      en = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_day", day, 0);
      chk("rst_mon", mon, 0);
      chk("rst_year", year, 0);
      chk("rst_dow", dow, 6);
      chk("rst_last_day", last_day, 0);
      chk("rst_last_mon", last_mon, 0);
      chk("rst_yr_wrap", yr_wrap, 0);
      chk("rst_ld_err", ld_err, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      en = 1'b1;
      for (int i = 0; i < 31; i++) begin
         if (i == 29) chk("jan30_last_day", last_day, 0);
         if (i == 30) chk("jan31_last_day", last_day, 1);
         step();
      end
      en = 1'b0;
      chk("feb1_day", day, 0);
      chk("feb1_mon", mon, 1);
      chk("feb1_dow", dow, 2);
      load(27, 1, 0, 0);
      chk("ld_feb28_day", day, 27);
      chk("ld_feb28_err", ld_err, 0);
      chk("leap_feb28_last", last_day, 0);
      chk("noleap_feb28_last", nl_last_day, 1);
      tick();
      chk("leap_feb29_day", day, 28);
      chk("leap_feb29_mon", mon, 1);
      chk("leap_feb29_last", last_day, 1);
      chk("noleap_mar1_day", nl_day, 0);
      chk("noleap_mar1_mon", nl_mon, 2);
      tick();
      chk("leap_mar1_day", day, 0);
      chk("leap_mar1_mon", mon, 2);
      chk("leap_mar1_dow", dow, 2);
      load(27, 1, 1, 0);
      tick();
      chk("y1_mar1_day", day, 0);
      chk("y1_mar1_mon", mon, 2);
      chk("y1_mar1_year", year, 1);
      load(30, 11, 99, 3);
      chk("dec31_last_mon", last_mon, 1);
      tick();
      chk("wrap_day", day, 0);
      chk("wrap_mon", mon, 0);
      chk("wrap_year", year, 0);
      chk("wrap_dow", dow, 4);
      chk("wrap_pulse", yr_wrap, 1);
      step();
      chk("wrap_pulse_end", yr_wrap, 0);
      load(5, 12, 3, 1);
      chk("bad_mon_err", ld_err, 1);
      chk("bad_mon_day", day, 0);
      chk("bad_mon_year", year, 0);
      chk("bad_mon_dow", dow, 4);
      step();
      chk("bad_mon_err_end", ld_err, 0);
      load(5, 2, 100, 1);
      chk("bad_year_err", ld_err, 1);
      chk("bad_year_year", year, 0);
      load(5, 2, 3, 7);
      chk("bad_dow_err", ld_err, 1);
      chk("bad_dow_dow", dow, 4);
      en = 1'b1;
      load(5, 13, 3, 1);
      en = 1'b0;
      chk("bad_ld_en_err", ld_err, 1);
      chk("bad_ld_en_day", day, 0);
      chk("bad_ld_en_dow", dow, 4);
      load(30, 3, 5, 2);
      chk("apr_clamp_day", day, 29);
      chk("apr_clamp_err", ld_err, 0);
      load(31, 1, 4, 2);
      chk("feb_leap_clamp", day, 28);
      chk("feb_noleap_clamp", nl_day, 27);
      en = 1'b1;
      load(10, 6, 20, 5);
      en = 1'b0;
      chk("ld_en_day", day, 10);
      chk("ld_en_mon", mon, 6);
      chk("ld_en_year", year, 20);
      chk("ld_en_dow", dow, 5);
      load(30, 11, 99, 0);
      en = 1'b1;
      @(posedge clk);
      #2;
      en = 1'b0;
      chk("pre_rst_wrap", yr_wrap, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_wrap", yr_wrap, 0);
      chk("async_rst_dow", dow, 6);
      chk("async_rst_day", day, 0);
      chk("async_rst_mon", mon, 0);
      chk("async_rst_year", year, 0);
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst_wrap", yr_wrap, 0);
      chk("post_rst_dow", dow, 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
